// File: rtl/util_fifo_pkg.sv
// rtl/util_fifo_pkg.sv - shared types and width helpers for the FIFO drain scheduler
//
// Purpose: FSM state encoding plus width-derivation functions used by the
// round-robin drain block and its stream interface.
//   cnt_width(depth)  : occupancy counter width, $clog2(depth)+1
//   ch_width(num_ch)  : channel index width, never less than 1
//   beat_width(len)   : burst beat counter width, $clog2(len)+1
package util_fifo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } drain_state_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int beat_width(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/util_fifo_rr_drain_if.sv
// rtl/util_fifo_rr_drain_if.sv - valid/ready output stream of the FIFO drain scheduler
//
// Purpose: bundles the drained word stream.
//   m_data  : output word
//   m_valid : word valid (never depends on m_ready)
//   m_ready : downstream ready
//   m_chan  : source channel of m_data
//   m_last  : final word of the current burst
// Modports: master (scheduler side), slave (downstream side).
interface util_fifo_rr_drain_if
  import util_fifo_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [CH_W-1:0]       m_chan;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_chan,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_chan,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/util_rr_pick.sv
// rtl/util_rr_pick.sv - combinational rotating-priority pick from a request vector
//
// Purpose: returns the first set request found searching upward from ptr,
// wrapping modulo N. Reusable by any round-robin arbiter.
//   req     : request vector, one bit per requester
//   ptr     : starting index of the search (must be < N)
//   grant   : index of the selected requester (0 when none)
//   any_req : at least one request is set
module util_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         any_req
);

  int           idx;
  logic [W-1:0] cand;

  // Walk offsets 0..N-1 from ptr; the first hit latches and later hits are ignored.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      cand = W'(idx);
      if (!any_req && req[cand]) begin
        grant   = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/util_fifo_rr_drain.sv
// rtl/util_fifo_rr_drain.sv - round-robin burst drain of NUM_CH FIFOs onto one stream
//
// Purpose: grants one FIFO at a time and pops up to BURST_LEN words from it,
// presenting them on a valid/ready stream tagged with channel and end of burst.
//   clk, rst   : clock, synchronous active-high reset
//   ch_en      : per-channel enable mask
//   flush      : lets any non-empty enabled channel go below the burst threshold
//   fifo_dout  : head word of each FIFO, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_dcnt  : occupancy of each FIFO, channel i at [i*CNT_W +: CNT_W]
//   fifo_empty : per-FIFO empty flags
//   fifo_rden  : per-FIFO pop strobes, at most one high
//   busy       : a grant is held
//   m_stream   : output stream (master modport)
module util_fifo_rr_drain
  import util_fifo_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 128,
  parameter  int BURST_LEN  = 16,
  localparam int CNT_W      = cnt_width(FIFO_DEPTH),
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic                         flush,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_dout,
  input  logic [NUM_CH*CNT_W-1:0]      fifo_dcnt,
  input  logic [NUM_CH-1:0]            fifo_empty,
  output logic [NUM_CH-1:0]            fifo_rden,
  output logic                         busy,
  util_fifo_rr_drain_if.master         m_stream
);

  localparam int                BEAT_W    = beat_width(BURST_LEN);
  localparam logic [CNT_W-1:0]  THRESH    = CNT_W'(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  drain_state_e          state, state_next;
  logic [CH_W-1:0]       rr_ptr, rr_ptr_next;
  logic [CH_W-1:0]       grant, grant_next;
  logic [BEAT_W-1:0]     beat_cnt, beat_cnt_next;

  logic [DATA_WIDTH-1:0] dout_arr [NUM_CH];
  logic [CNT_W-1:0]      dcnt_arr [NUM_CH];
  logic [NUM_CH-1:0]     elig;
  logic [CH_W-1:0]       pick;
  logic                  any_elig;

  logic                  in_burst;
  logic [CH_W-1:0]       sel;
  logic                  valid;
  logic                  last;
  logic                  beat;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign dout_arr[i] = fifo_dout[i*DATA_WIDTH +: DATA_WIDTH];
    assign dcnt_arr[i] = fifo_dcnt[i*CNT_W +: CNT_W];
    assign elig[i]     = ch_en[i] & ~fifo_empty[i] & ((dcnt_arr[i] >= THRESH) | flush);
  end

  util_rr_pick #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_pick (
    .req     (elig),
    .ptr     (rr_ptr),
    .grant   (pick),
    .any_req (any_elig)
  );

  // Reset is folded into the output path so that the reset cycle itself already
  // shows an idle stream and no pop, even though state still holds the old burst.
  assign in_burst = ~rst & (state == BURST);
  assign sel      = rst ? '0 : grant;

  // Ending on dcnt==1 keeps a burst from stalling on a FIFO it just emptied.
  assign valid = in_burst & ~fifo_empty[sel];
  assign last  = valid & ((beat_cnt == LAST_BEAT) | (dcnt_arr[sel] == CNT_W'(1)));
  assign beat  = valid & m_stream.m_ready;

  assign m_stream.m_valid = valid;
  assign m_stream.m_last  = last;
  assign m_stream.m_data  = dout_arr[sel];
  assign m_stream.m_chan  = sel;
  assign busy             = in_burst;

  always_comb begin
    fifo_rden      = '0;
    fifo_rden[sel] = beat;
  end

  always_comb begin
    state_next    = state;
    rr_ptr_next   = rr_ptr;
    grant_next    = grant;
    beat_cnt_next = beat_cnt;
    case (state)
      IDLE: begin
        if (any_elig) begin
          grant_next    = pick;
          beat_cnt_next = '0;
          state_next    = BURST;
        end
      end
      BURST: begin
        if (beat) begin
          beat_cnt_next = beat_cnt + 1'b1;
          if (last) begin
            state_next  = IDLE;
            rr_ptr_next = (grant == LAST_CH) ? '0 : grant + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_ptr_next;
      grant    <= grant_next;
      beat_cnt <= beat_cnt_next;
    end
  end

endmodule

// File: tb/tb_util_fifo_rr_drain.sv
// tb/tb_util_fifo_rr_drain.sv - self-checking bench for the round-robin FIFO drain
module tb_util_fifo_rr_drain;
  localparam int NCH   = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 128;
  localparam int BL    = 16;
  localparam int CNT_W = 8;
  localparam int CH_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       ch_en;
  logic                 flush;
  logic [NCH*DW-1:0]    fifo_dout;
  logic [NCH*CNT_W-1:0] fifo_dcnt;
  logic [NCH-1:0]       fifo_empty;
  logic [NCH-1:0]       fifo_rden;
  logic                 busy;

  util_fifo_rr_drain_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) m_if ();

  util_fifo_rr_drain #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .flush(flush),
    .fifo_dout(fifo_dout), .fifo_dcnt(fifo_dcnt), .fifo_empty(fifo_empty),
    .fifo_rden(fifo_rden), .busy(busy), .m_stream(m_if)
  );

  always #5 clk = ~clk;

  // FIFO contents driven into the DUT, and an independent write-order log.
  logic [DW-1:0] mem [NCH][DEPTH];
  int            rp [NCH], wp [NCH], cnt [NCH], pops [NCH];
  logic [DW-1:0] sbm [NCH][1024];
  int            sb_wr [NCH], sb_rd [NCH];

  // Burst-level reference: list of (channel, length) and leftover counts.
  int exp_ch [64], exp_len [64], n_exp, rem [NCH], m_ptr;

  int n_chk, n_pass, n_fail;

  logic            s_valid, s_ready, s_last, s_busy;
  logic [DW-1:0]   s_data;
  logic [CH_W-1:0] s_chan;
  logic [NCH-1:0]  s_rden;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] head_word(input int c);
    return (cnt[c] > 0) ? mem[c][rp[c]] : (32'hDEAD_BEE0 | 32'(c));
  endfunction

  task automatic refresh();
    for (int i = 0; i < NCH; i++) begin
      fifo_empty[i]                = (cnt[i] == 0);
      fifo_dcnt[i*CNT_W +: CNT_W]  = CNT_W'(cnt[i]);
      fifo_dout[i*DW +: DW]        = head_word(i);
    end
  endtask

  task automatic push(input int c, input int n);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      mem[c][wp[c]] = w;
      wp[c] = (wp[c] + 1) % DEPTH;
      cnt[c]++;
      sbm[c][sb_wr[c] % 1024] = w;
      sb_wr[c]++;
    end
    refresh();
  endtask

  // Sample outputs mid-cycle, then apply the pops the DUT requested at the edge.
  task automatic cyc();
    @(negedge clk);
    s_valid = m_if.m_valid; s_ready = m_if.m_ready; s_data = m_if.m_data;
    s_chan  = m_if.m_chan;  s_last  = m_if.m_last;  s_busy = busy; s_rden = fifo_rden;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (s_rden[i] && cnt[i] > 0) begin
        rp[i] = (rp[i] + 1) % DEPTH;
        cnt[i]--;
        pops[i]++;
      end
    end
    refresh();
  endtask

  task automatic predict();
    int pick, len;
    n_exp = 0;
    for (int i = 0; i < NCH; i++) rem[i] = cnt[i];
    while (1) begin
      pick = -1;
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (pick < 0 && ch_en[c] && rem[c] > 0 && (rem[c] >= BL || flush)) pick = c;
      end
      if (pick < 0) break;
      len = (rem[pick] < BL) ? rem[pick] : BL;
      exp_ch[n_exp] = pick; exp_len[n_exp] = len; n_exp++;
      rem[pick] -= len;
      m_ptr = (pick + 1) % NCH;
    end
  endtask

  task automatic do_reset(input int ncyc);
    logic [DW-1:0] e0;
    rst = 1'b1;
    m_if.m_ready = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      e0 = head_word(0);
      cyc();
      chk("rst_valid", s_valid, 0); chk("rst_busy", s_busy, 0); chk("rst_rden", s_rden, 0);
      chk("rst_last", s_last, 0);   chk("rst_chan", s_chan, 0); chk("rst_data", s_data, e0);
    end
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      m_if.m_ready = 1'b1;
      cyc();
      chk("quiet_valid", s_valid, 0); chk("quiet_busy", s_busy, 0); chk("quiet_rden", s_rden, 0);
    end
  endtask

  // One idle cycle precedes every burst (grant latency / inter-burst gap).
  task automatic run_expect(input bit rnd, input int mask_beat, input int mask_ch);
    int b, beat, budget, idle_left, c;
    logic [DW-1:0] ew;
    b = 0; beat = 0; budget = 0; idle_left = 1;
    while (b < n_exp && budget < 3000) begin
      m_if.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      budget++;
      if (idle_left > 0) begin
        chk("gap_valid", s_valid, 0); chk("gap_busy", s_busy, 0); chk("gap_rden", s_rden, 0);
        idle_left--;
      end else begin
        c  = exp_ch[b];
        ew = sbm[c][sb_rd[c] % 1024];
        chk("valid", s_valid, 1); chk("busy", s_busy, 1);
        chk("chan", s_chan, c);   chk("data", s_data, ew);
        chk("last", s_last, (beat == exp_len[b] - 1));
        if (s_ready) begin
          chk("beat_rden", s_rden, 1 << c);
          sb_rd[c]++;
          beat++;
          if (mask_ch >= 0 && b == 0 && beat == mask_beat) ch_en[mask_ch] = 1'b0;
          if (beat == exp_len[b]) begin
            b++; beat = 0; idle_left = 1;
          end
        end else begin
          chk("stall_rden", s_rden, 0);
        end
      end
    end
    chk("bursts_done", b, n_exp);
  endtask

  initial begin
    int p, nb;
    logic [DW-1:0] ew;
    n_chk = 0; n_pass = 0; n_fail = 0; m_ptr = 0;
    for (int i = 0; i < NCH; i++) begin
      rp[i] = 0; wp[i] = 0; cnt[i] = 0; pops[i] = 0; sb_wr[i] = 0; sb_rd[i] = 0;
    end
    rst = 1'b1; ch_en = '1; flush = 1'b0; m_if.m_ready = 1'b1;
    refresh();
    do_reset(2);

    // Single channel: 16-word burst, remainder waits for flush.
    push(1, 20);
    predict();
    run_expect(1'b0, -1, -1);
    chk("ch1_left", cnt[1], 4);
    idle_check(5);
    flush = 1'b1;
    predict();
    chk("flush_burst_len", exp_len[0], 4);
    run_expect(1'b0, -1, -1);
    flush = 1'b0;
    chk("ch1_drained", cnt[1], 0);
    idle_check(2);

    // Round robin over four full channels, pointer wraps 3 -> 0.
    do_reset(1);
    for (int c = 0; c < NCH; c++) push(c, 32);
    predict();
    chk("rr_bursts", n_exp, 8);
    run_expect(1'b0, -1, -1);
    idle_check(3);

    // Backpressure on a ch2 burst.
    push(2, 16);
    p = pops[2];
    predict();
    run_expect(1'b1, -1, -1);
    chk("bp_pops", pops[2] - p, 16);
    idle_check(2);

    // Drain to empty with flush.
    push(0, 5);
    flush = 1'b1;
    p = pops[0];
    predict();
    run_expect(1'b0, -1, -1);
    flush = 1'b0;
    chk("drain_pops", pops[0] - p, 5);
    chk("drain_empty", fifo_empty[0], 1);
    idle_check(2);

    // Mask mid-burst: ch1 burst completes, then ch1 is skipped.
    do_reset(1);
    push(1, 32); push(2, 16);
    n_exp = 2; exp_ch[0] = 1; exp_len[0] = 16; exp_ch[1] = 2; exp_len[1] = 16;
    m_ptr = 3;
    run_expect(1'b0, 3, 1);
    idle_check(3);
    ch_en = '1;
    predict();
    run_expect(1'b0, -1, -1);

    // Reset at beat 7 of a ch3 burst; afterwards search restarts at ch0.
    push(3, 30); push(0, 16);
    predict();
    chk("pre_rst_pick", exp_ch[0], 3);
    p = pops[3]; nb = 0;
    for (int k = 0; k < 100 && nb < 7; k++) begin
      m_if.m_ready = 1'b1;
      cyc();
      if (s_valid && s_ready) begin
        ew = sbm[3][sb_rd[3] % 1024];
        chk("pre_rst_chan", s_chan, 3); chk("pre_rst_data", s_data, ew);
        sb_rd[3]++; nb++;
      end
    end
    chk("pre_rst_beats", nb, 7);
    do_reset(1);
    chk("rst_no_pop", pops[3] - p, 7);
    predict();
    chk("post_rst_pick", exp_ch[0], 0);
    run_expect(1'b0, -1, -1);
    idle_check(2);

    // Randomized rounds against the burst-level model.
    for (int it = 0; it < 3; it++) begin
      for (int c = 0; c < NCH; c++) if ($urandom_range(0, 1) == 1) push(c, $urandom_range(0, 35));
      ch_en = 4'($urandom);
      flush = 1'($urandom_range(0, 1));
      predict();
      run_expect(1'b1, -1, -1);
      idle_check(3);
      for (int c = 0; c < NCH; c++) chk("rand_left", cnt[c], rem[c]);
    end

    // Final flush drains everything.
    ch_en = '1; flush = 1'b1;
    predict();
    run_expect(1'b1, -1, -1);
    for (int c = 0; c < NCH; c++) chk("final_empty", fifo_empty[c], 1);
    flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
